key_debounce_enc: RTL
=====================

KEY_DEBOUNCE_ENC -- requirements
Module: key_debounce_enc

Interface
REQ-001 SHALL have parameter T_20MS, 20 bits, default 20'hF_4240: debounce stable-time in clk cycles; minimum legal value 2.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port bt, input, 10 bits: raw digit keys 0-9, active-high, asynchronous to clk, bouncing.
REQ-005 SHALL have port btstar, input, 1 bit: raw '*' (enter) key, active-low, asynchronous, bouncing.
REQ-006 SHALL have port key_vld, output, 1 bit: one-cycle pulse when a single digit press is accepted.
REQ-007 SHALL have port key_code, output, 4 bits: digit 0-9, valid while key_vld is high.
REQ-008 SHALL have port star_vld, output, 1 bit: one-cycle pulse when a '*' press is accepted.
REQ-009 SHALL have port key_err, output, 1 bit: one-cycle pulse on a rejected simultaneous press.

Function
REQ-010 SHALL invert btstar and form an 11-bit raw vector {star, bt[9:0]}, then pass it through a 2-flop synchronizer (s1, s2).
REQ-011 SHALL register s2 into prev each cycle; any bit difference s2 != prev SHALL clear the shared 20-bit stable counter to 0.
REQ-012 While s2 == prev, the counter SHALL increment by 1 and saturate at T_20MS-1, with no wrap.
REQ-013 When the counter equals T_20MS-1 and s2 == prev, the debounced vector db SHALL load s2; otherwise db SHALL hold.
REQ-014 SHALL register db into db_d; the rising-edge vector rise = db & ~db_d; release edges SHALL produce no output.
REQ-015 Outputs SHALL be registered: after a raw change held stable, the pulse SHALL be high in the cycle after rising edge T_20MS+4, counting from the first edge that samples the new level.
REQ-016 A bounce shorter than T_20MS cycles SHALL restart the counter and produce no pulse; the pulse SHALL occur T_20MS+4 edges after the last transition.
REQ-017 If rise has exactly one digit bit set and the star bit is clear, SHALL assert key_vld for 1 cycle with key_code set to that bit index.
REQ-018 If the star bit of rise is set and no digit bit is set, SHALL assert star_vld for 1 cycle.
REQ-019 If more than one bit of rise is set, including digit plus star, SHALL assert key_err for 1 cycle; key_vld and star_vld SHALL stay low.
REQ-020 A key held down SHALL produce exactly one pulse, with no auto-repeat; a further pulse SHALL require release and a new debounced press.
REQ-021 A press of a second key while the first is held SHALL be accepted as a normal single rise.
REQ-022 key_code SHALL hold its last value when key_vld is low.
REQ-023 key_vld, star_vld and key_err SHALL never be high in the same cycle.

Reset
REQ-024 On rst high, SHALL immediately clear s1, s2, prev, db, db_d, counter, key_vld, star_vld, key_err, and set key_code to 4'h0.
REQ-025 A key already held at reset release SHALL be accepted once after T_20MS+4 edges, because db starts at 0.
REQ-026 Reset asserted mid-debounce SHALL discard the pending count; no pulse SHALL follow from pre-reset activity except per REQ-025.

Structure
REQ-027 The key count (10), star bit index (10) and vector width (11) SHALL be shared constants in the doorlock defines include, alongside the T_20MS default.
REQ-028 The synchronizer, stable counter and db register SHALL form one sub-module, sync_debounce, parameterised by width and T_20MS; key_debounce_enc SHALL add the edge detect and encoder.
REQ-029 key_debounce_enc SHALL feed the doorlock FSM directly; the FSM SHALL consume only key_vld, key_code, star_vld and key_err.

Verification (T_20MS = 8)
REQ-030 Clean bt[7] press held 30 cycles -> one key_vld pulse, key_code=7, 12 edges after the first sampling edge.
REQ-031 bt[1] bouncing 2/1/3/1 cycles, then held 20 cycles -> exactly one key_vld, key_code=1, 12 edges after the last rise; no pulse on release bounce.
REQ-032 btstar low for 20 cycles -> one star_vld; key_vld and key_err stay 0.
REQ-033 bt[2] and bt[5] rising in the same cycle and held -> one key_err; no key_vld.
REQ-034 rst pulsed 5 cycles into a debounce, key still held -> no pulse before rst falls; one key_vld 12 edges after rst release.
REQ-035 bt[2] held 100 cycles -> exactly one key_vld over the whole window.

Source files
------------

// File: rtl/key_debounce_enc_pkg.sv
// Shared constants and helpers for the keypad debounce/encoder slice.
// The keypad vector is {star, digit[9:0]}; star sits at the top bit.
package key_debounce_enc_pkg;

  localparam int          NUM_KEYS   = 10;
  localparam int          STAR_IDX   = 10;
  localparam int          VEC_W      = 11;
  localparam logic [19:0] T_20MS_DEF = 20'hF_4240;

  typedef logic [VEC_W-1:0] key_vec_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_KEY  = 2'd1,
    EV_STAR = 2'd2,
    EV_ERR  = 2'd3
  } key_event_e;

  function automatic logic [3:0] bit_count(input key_vec_t v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < VEC_W; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Index of the lowest set digit bit; only meaningful when exactly one is set.
  function automatic logic [3:0] digit_index(input key_vec_t v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_debounce_enc_if.sv
// Keypad bundle: raw key lines in, accepted-key event pulses out.
// Events are valid-only pulses with no ready: each of key_vld, star_vld and
// key_err is high for exactly one cycle and the consumer must take it then;
// key_code is meaningful while key_vld is high and holds its value otherwise.
interface key_debounce_enc_if;
  logic [key_debounce_enc_pkg::NUM_KEYS-1:0] bt;
  logic                                      btstar;
  logic                                      key_vld;
  logic [3:0]                                key_code;
  logic                                      star_vld;
  logic                                      key_err;

  modport master (
    input  bt, btstar,
    output key_vld, key_code, star_vld, key_err
  );

  modport slave (
    output bt, btstar,
    input  key_vld, key_code, star_vld, key_err
  );
endinterface

// File: rtl/key_debounce_enc_sync_debounce.sv
// Two-flop synchronizer plus shared stable-time counter; db follows the
// synchronized vector only once the whole vector has been steady long enough.
module sync_debounce #(
  parameter int          W      = 11,
  parameter logic [19:0] T_20MS = 20'hF_4240
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db
);

  localparam logic [19:0] CNT_MAX = T_20MS - 20'd1;

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] prev;
  logic [19:0]  cnt;
  logic         steady;

  assign steady = (s2 == prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      cnt  <= 20'd0;
      db   <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
      // Any change on any line restarts the shared count; it saturates, never wraps.
      if (!steady) begin
        cnt <= 20'd0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 20'd1;
      end
      if (steady && (cnt == CNT_MAX)) begin
        db <= s2;
      end
    end
  end

endmodule

// File: rtl/key_debounce_enc.sv
// Keypad front end: debounce all keys together, detect press edges and
// encode them into single-digit, star or simultaneous-press error pulses.
module key_debounce_enc
  import key_debounce_enc_pkg::*;
#(
  parameter logic [19:0] T_20MS = T_20MS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  key_debounce_enc_if.master kif
);

  key_vec_t   raw;
  key_vec_t   db;
  key_vec_t   db_d;
  key_vec_t   rise;
  key_event_e ev;
  logic [3:0] ev_code;
  logic       key_vld_q;
  logic       star_vld_q;
  logic       key_err_q;
  logic [3:0] key_code_q;

  // btstar is active-low on the pins; internally every key is active-high.
  assign raw = {~kif.btstar, kif.bt};

  sync_debounce #(
    .W      (VEC_W),
    .T_20MS (T_20MS)
  ) u_sync_debounce (
    .clk (clk),
    .rst (rst),
    .raw (raw),
    .db  (db)
  );

  // Only press edges matter; releases are dropped here.
  assign rise = db & ~db_d;

  always_comb begin
    ev      = EV_NONE;
    ev_code = digit_index(rise);
    if (bit_count(rise) > 4'd1) begin
      ev = EV_ERR;
    end else if (bit_count(rise) == 4'd1) begin
      ev = rise[STAR_IDX] ? EV_STAR : EV_KEY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_d       <= '0;
      key_vld_q  <= 1'b0;
      star_vld_q <= 1'b0;
      key_err_q  <= 1'b0;
      key_code_q <= 4'h0;
    end else begin
      db_d       <= db;
      key_vld_q  <= (ev == EV_KEY);
      star_vld_q <= (ev == EV_STAR);
      key_err_q  <= (ev == EV_ERR);
      if (ev == EV_KEY) begin
        key_code_q <= ev_code;
      end
    end
  end

  assign kif.key_vld  = key_vld_q;
  assign kif.star_vld = star_vld_q;
  assign kif.key_err  = key_err_q;
  assign kif.key_code = key_code_q;

endmodule
